// File: rtl/fetch_parcel_splitter_pkg.sv
// rtl/fetch_parcel_splitter_pkg.sv - shared frontend parameters and fetch/instruction structs
package fetch_parcel_splitter_pkg;

  localparam int FETCH_BYTES   = 16;
  localparam int HW_PER_BUNDLE = 8;
  localparam int PC_W          = 40;
  localparam int HW_IDX_W      = 3;

  typedef struct packed {
    logic [PC_W-1:0]            pc;
    logic [FETCH_BYTES*8-1:0]   data;
    logic [HW_PER_BUNDLE-1:0]   mask;
    logic                       xcpt_pf;
    logic                       xcpt_ae;
  } fetch_bundle_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
    logic            is_rvc;
    logic            edge_inst;
    logic            xcpt_pf;
    logic            xcpt_ae;
  } inst_out_t;

  function automatic logic [PC_W-1:0] hw_pc(input logic [PC_W-1:0] base,
                                            input logic [HW_IDX_W-1:0] idx);
    return base + {{(PC_W-HW_IDX_W-1){1'b0}}, idx, 1'b0};
  endfunction

endpackage

// File: rtl/fetch_parcel_splitter_hw_first_set.sv
// rtl/fetch_parcel_splitter_hw_first_set.sv - lowest set mask bit at or above a start index
module hw_first_set
  import fetch_parcel_splitter_pkg::*;
(
  input  logic [HW_PER_BUNDLE-1:0] mask_i,
  input  logic [HW_IDX_W-1:0]      start_i,
  output logic                     found_o,
  output logic [HW_IDX_W-1:0]      idx_o
);

  // Scan downward so the lowest qualifying index is the last one written.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = HW_PER_BUNDLE-1; i >= 0; i--) begin
      if (mask_i[i] && (HW_IDX_W'(i) >= start_i)) begin
        found_o = 1'b1;
        idx_o   = HW_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/fetch_parcel_splitter.sv
// rtl/fetch_parcel_splitter.sv - splits 16-byte fetch bundles into RVC/32-bit instructions
module fetch_parcel_splitter
  import fetch_parcel_splitter_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_flush,
  input  logic                       io_enq_valid,
  output logic                       io_enq_ready,
  input  logic [PC_W-1:0]            io_enq_bits_pc,
  input  logic [FETCH_BYTES*8-1:0]   io_enq_bits_data,
  input  logic [HW_PER_BUNDLE-1:0]   io_enq_bits_mask,
  input  logic                       io_enq_bits_xcpt_pf_inst,
  input  logic                       io_enq_bits_xcpt_ae_inst,
  output logic                       io_deq_valid,
  input  logic                       io_deq_ready,
  output logic [PC_W-1:0]            io_deq_bits_pc,
  output logic [31:0]                io_deq_bits_inst,
  output logic                       io_deq_bits_is_rvc,
  output logic                       io_deq_bits_edge_inst,
  output logic                       io_deq_bits_xcpt_pf_inst,
  output logic                       io_deq_bits_xcpt_ae_inst
);

  fetch_bundle_t         bundle_q, bundle_d;
  logic                  bundle_valid_q, bundle_valid_d;
  logic [HW_IDX_W-1:0]   ptr_q, ptr_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [15:0]           pend_hw_q, pend_hw_d;
  logic [PC_W-1:0]       pend_pc_q, pend_pc_d;

  inst_out_t             deq_bits;
  logic                  found;
  logic [HW_IDX_W-1:0]   idx, idx_p1;
  logic [15:0]           hw_lo, hw_hi;
  logic [HW_IDX_W:0]     nxt;
  logic                  rem_any, deq_valid, retire, store_pend, clr_pend;
  logic                  xcpt, edge_ok, enq_fire, deq_fire;
  logic [PC_W-1:0]       pend_next_pc;

  hw_first_set u_first_set (
    .mask_i  (bundle_q.mask),
    .start_i (ptr_q),
    .found_o (found),
    .idx_o   (idx)
  );

  assign idx_p1       = idx + 3'd1;
  assign hw_lo        = bundle_q.data[{idx, 4'h0} +: 16];
  assign hw_hi        = bundle_q.data[{idx_p1, 4'h0} +: 16];
  assign xcpt         = bundle_q.xcpt_pf | bundle_q.xcpt_ae;
  assign pend_next_pc = pend_pc_q + PC_W'(2);
  assign edge_ok      = pend_valid_q && (ptr_q == '0) && (bundle_q.pc == pend_next_pc)
                        && bundle_q.mask[0];

  always_comb begin
    deq_bits   = '0;
    deq_valid  = 1'b0;
    retire     = 1'b0;
    store_pend = 1'b0;
    clr_pend   = 1'b0;
    rem_any    = 1'b0;
    nxt        = {1'b0, ptr_q};
    if (bundle_valid_q) begin
      if (xcpt) begin
        // idx is 0 when nothing is found, so this also yields base for an empty mask.
        deq_valid        = 1'b1;
        deq_bits.pc      = hw_pc(bundle_q.pc, idx);
        deq_bits.xcpt_pf = bundle_q.xcpt_pf;
        deq_bits.xcpt_ae = bundle_q.xcpt_ae;
        clr_pend         = 1'b1;
        retire           = io_deq_ready;
      end else if (edge_ok) begin
        deq_valid          = 1'b1;
        deq_bits.pc        = pend_pc_q;
        deq_bits.inst      = {bundle_q.data[15:0], pend_hw_q};
        deq_bits.edge_inst = 1'b1;
        nxt                = 4'd1;
        clr_pend           = io_deq_ready;
      end else begin
        clr_pend = pend_valid_q;
        if (!found) begin
          retire = 1'b1;
        end else if (hw_lo[1:0] != 2'b11) begin
          deq_valid       = 1'b1;
          deq_bits.pc     = hw_pc(bundle_q.pc, idx);
          deq_bits.inst   = {16'h0, hw_lo};
          deq_bits.is_rvc = 1'b1;
          nxt             = {1'b0, idx} + 4'd1;
        end else if (idx != 3'd7) begin
          if (bundle_q.mask[idx_p1]) begin
            deq_valid     = 1'b1;
            deq_bits.pc   = hw_pc(bundle_q.pc, idx);
            deq_bits.inst = {hw_hi, hw_lo};
            nxt           = {1'b0, idx} + 4'd2;
          end else begin
            retire = 1'b1;
          end
        end else begin
          store_pend = 1'b1;
          retire     = 1'b1;
        end
      end
      rem_any = |(bundle_q.mask >> nxt);
      if (deq_valid && !xcpt && io_deq_ready && !rem_any) begin
        retire = 1'b1;
      end
    end
  end

  assign io_deq_valid = deq_valid & ~io_flush & ~reset;
  assign io_enq_ready = ~reset & ~io_flush & (~bundle_valid_q | retire);
  assign enq_fire     = io_enq_valid & io_enq_ready;
  assign deq_fire     = io_deq_valid & io_deq_ready;

  assign io_deq_bits_pc           = deq_bits.pc;
  assign io_deq_bits_inst         = deq_bits.inst;
  assign io_deq_bits_is_rvc       = deq_bits.is_rvc;
  assign io_deq_bits_edge_inst    = deq_bits.edge_inst;
  assign io_deq_bits_xcpt_pf_inst = deq_bits.xcpt_pf;
  assign io_deq_bits_xcpt_ae_inst = deq_bits.xcpt_ae;

  always_comb begin
    bundle_d       = bundle_q;
    bundle_valid_d = bundle_valid_q & ~retire;
    ptr_d          = deq_fire ? nxt[HW_IDX_W-1:0] : ptr_q;
    pend_valid_d   = pend_valid_q & ~clr_pend;
    pend_hw_d      = pend_hw_q;
    pend_pc_d      = pend_pc_q;
    if (store_pend) begin
      pend_valid_d = 1'b1;
      pend_hw_d    = hw_lo;
      pend_pc_d    = hw_pc(bundle_q.pc, 3'd7);
    end
    if (enq_fire) begin
      bundle_valid_d   = 1'b1;
      ptr_d            = '0;
      bundle_d.pc      = io_enq_bits_pc & ~PC_W'(15);
      bundle_d.data    = io_enq_bits_data;
      bundle_d.mask    = io_enq_bits_mask;
      bundle_d.xcpt_pf = io_enq_bits_xcpt_pf_inst;
      bundle_d.xcpt_ae = io_enq_bits_xcpt_ae_inst;
    end
    if (io_flush) begin
      bundle_valid_d = 1'b0;
      pend_valid_d   = 1'b0;
      ptr_d          = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bundle_valid_q <= 1'b0;
      pend_valid_q   <= 1'b0;
      ptr_q          <= '0;
    end else begin
      bundle_valid_q <= bundle_valid_d;
      pend_valid_q   <= pend_valid_d;
      ptr_q          <= ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    bundle_q  <= bundle_d;
    pend_hw_q <= pend_hw_d;
    pend_pc_q <= pend_pc_d;
  end

endmodule

// File: tb/tb_fetch_parcel_splitter.sv
// tb/tb_fetch_parcel_splitter.sv - directed self-checking bench for fetch_parcel_splitter
module tb_fetch_parcel_splitter;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         io_flush = 1'b0;
  logic         io_enq_valid = 1'b0;
  logic         io_enq_ready;
  logic [39:0]  io_enq_bits_pc = '0;
  logic [127:0] io_enq_bits_data = '0;
  logic [7:0]   io_enq_bits_mask = '0;
  logic         io_enq_bits_xcpt_pf_inst = 1'b0;
  logic         io_enq_bits_xcpt_ae_inst = 1'b0;
  logic         io_deq_valid;
  logic         io_deq_ready = 1'b0;
  logic [39:0]  io_deq_bits_pc;
  logic [31:0]  io_deq_bits_inst;
  logic         io_deq_bits_is_rvc;
  logic         io_deq_bits_edge_inst;
  logic         io_deq_bits_xcpt_pf_inst;
  logic         io_deq_bits_xcpt_ae_inst;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clock = ~clock;

  fetch_parcel_splitter dut (
    .clock                    (clock),
    .reset                    (reset),
    .io_flush                 (io_flush),
    .io_enq_valid             (io_enq_valid),
    .io_enq_ready             (io_enq_ready),
    .io_enq_bits_pc           (io_enq_bits_pc),
    .io_enq_bits_data         (io_enq_bits_data),
    .io_enq_bits_mask         (io_enq_bits_mask),
    .io_enq_bits_xcpt_pf_inst (io_enq_bits_xcpt_pf_inst),
    .io_enq_bits_xcpt_ae_inst (io_enq_bits_xcpt_ae_inst),
    .io_deq_valid             (io_deq_valid),
    .io_deq_ready             (io_deq_ready),
    .io_deq_bits_pc           (io_deq_bits_pc),
    .io_deq_bits_inst         (io_deq_bits_inst),
    .io_deq_bits_is_rvc       (io_deq_bits_is_rvc),
    .io_deq_bits_edge_inst    (io_deq_bits_edge_inst),
    .io_deq_bits_xcpt_pf_inst (io_deq_bits_xcpt_pf_inst),
    .io_deq_bits_xcpt_ae_inst (io_deq_bits_xcpt_ae_inst)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input logic v, input logic [39:0] pc, input logic [127:0] d,
                       input logic [7:0] m, input logic pf);
    io_enq_valid             = v;
    io_enq_bits_pc           = pc;
    io_enq_bits_data         = d;
    io_enq_bits_mask         = m;
    io_enq_bits_xcpt_pf_inst = pf;
    io_enq_bits_xcpt_ae_inst = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [39:0] pc, input logic [31:0] inst,
                            input logic rvc, input logic edg, input logic pf);
    check_eq({tag, ".valid"}, 64'(io_deq_valid), 64'd1);
    check_eq({tag, ".pc"},    64'(io_deq_bits_pc), 64'(pc));
    check_eq({tag, ".inst"},  64'(io_deq_bits_inst), 64'(inst));
    check_eq({tag, ".rvc"},   64'(io_deq_bits_is_rvc), 64'(rvc));
    check_eq({tag, ".edge"},  64'(io_deq_bits_edge_inst), 64'(edg));
    check_eq({tag, ".pf"},    64'(io_deq_bits_xcpt_pf_inst), 64'(pf));
    check_eq({tag, ".ae"},    64'(io_deq_bits_xcpt_ae_inst), 64'd0);
  endtask

  // Seven RVC parcels then a 32-bit head at hw7, followed by a one-halfword bundle.
  task automatic edge_case(input string tag, input logic [39:0] nxt_pc, input logic [15:0] nxt_hw,
                           input logic [39:0] exp_pc, input logic [31:0] exp_inst,
                           input logic exp_rvc, input logic exp_edge);
    cyc();
    drive(1'b1, 40'h3000, {16'h0003, {7{16'h0001}}}, 8'hFF, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cyc();
      if (i == 0) io_enq_valid = 1'b0;
      #1;
      expect_out($sformatf("%s.rvc%0d", tag, i), 40'h3000 + 40'(2*i), 32'h1, 1'b1, 1'b0, 1'b0);
    end
    cyc();
    drive(1'b1, nxt_pc, {112'h0, nxt_hw}, 8'h01, 1'b0);
    #1;
    check_eq({tag, ".gap_valid"}, 64'(io_deq_valid), 64'd0);
    check_eq({tag, ".gap_enq_rdy"}, 64'(io_enq_ready), 64'd1);
    cyc();
    io_enq_valid = 1'b0;
    #1;
    expect_out({tag, ".first"}, exp_pc, exp_inst, exp_rvc, exp_edge, 1'b0);
    check_eq({tag, ".final_rdy"}, 64'(io_enq_ready), 64'd1);
    cyc();
    #1;
    check_eq({tag, ".idle"}, 64'(io_deq_valid), 64'd0);
  endtask

  logic [127:0] d32;

  initial begin
    cyc();
    #1;
    check_eq("rst.deq_valid", 64'(io_deq_valid), 64'd0);
    check_eq("rst.enq_ready", 64'(io_enq_ready), 64'd0);
    reset = 1'b0;
    cyc();
    #1;
    check_eq("rst.enq_ready_after", 64'(io_enq_ready), 64'd1);
    check_eq("rst.deq_valid_after", 64'(io_deq_valid), 64'd0);

    for (int j = 0; j < 4; j++) d32[32*j +: 32] = {16'h1000 + 16'(j), 16'h0013};

    cyc();
    io_deq_ready = 1'b1;
    drive(1'b1, 40'h1000, {8{16'h0001}}, 8'hFF, 1'b0);
    #1;
    check_eq("t31.accept_rdy", 64'(io_enq_ready), 64'd1);
    check_eq("t31.no_early", 64'(io_deq_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 0) io_enq_valid = 1'b0;
      if (i == 7) drive(1'b1, 40'h2000, d32, 8'hFF, 1'b0);
      #1;
      expect_out($sformatf("t31.%0d", i), 40'h1000 + 40'(2*i), 32'h1, 1'b1, 1'b0, 1'b0);
      check_eq($sformatf("t31.enq_rdy%0d", i), 64'(io_enq_ready), 64'(i == 7));
    end

    for (int j = 0; j < 4; j++) begin
      cyc();
      if (j == 0) io_enq_valid = 1'b0;
      #1;
      expect_out($sformatf("t32.%0d", j), 40'h2000 + 40'(4*j), {16'h1000 + 16'(j), 16'h0013},
                 1'b0, 1'b0, 1'b0);
      check_eq($sformatf("t32.enq_rdy%0d", j), 64'(io_enq_ready), 64'(j == 3));
    end
    cyc();
    #1;
    check_eq("t32.idle", 64'(io_deq_valid), 64'd0);

    edge_case("t33", 40'h3010, 16'hABCD, 40'h300E, 32'hABCD0003, 1'b0, 1'b1);
    edge_case("t34", 40'h4000, 16'h0001, 40'h4000, 32'h00000001, 1'b1, 1'b0);

    cyc();
    drive(1'b1, 40'h5006, {8{16'h0001}}, 8'hF8, 1'b1);
    cyc();
    io_enq_valid = 1'b0;
    io_enq_bits_xcpt_pf_inst = 1'b0;
    #1;
    expect_out("t35", 40'h5006, 32'h0, 1'b0, 1'b0, 1'b1);
    check_eq("t35.enq_rdy", 64'(io_enq_ready), 64'd1);
    cyc();
    #1;
    check_eq("t35.idle", 64'(io_deq_valid), 64'd0);

    cyc();
    drive(1'b1, 40'h6000, {80'h0, 16'h0001, 16'h0000, 16'h0003}, 8'h05, 1'b0);
    cyc();
    io_enq_valid = 1'b0;
    #1;
    check_eq("mal.valid", 64'(io_deq_valid), 64'd0);
    check_eq("mal.enq_rdy", 64'(io_enq_ready), 64'd1);
    cyc();
    #1;
    check_eq("mal.dropped", 64'(io_deq_valid), 64'd0);

    cyc();
    drive(1'b1, 40'h7000, {16'h0003, 112'h0}, 8'h80, 1'b0);
    cyc();
    drive(1'b1, 40'h7010, {112'h0, 16'hBEEF}, 8'h01, 1'b0);
    #1;
    check_eq("t36.pend_valid", 64'(io_deq_valid), 64'd0);
    check_eq("t36.pend_rdy", 64'(io_enq_ready), 64'd1);
    io_deq_ready = 1'b0;
    cyc();
    io_enq_valid = 1'b0;
    #1;
    expect_out("t36.edge", 40'h700E, 32'hBEEF0003, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      expect_out($sformatf("t36.hold%0d", k), 40'h700E, 32'hBEEF0003, 1'b0, 1'b1, 1'b0);
    end
    cyc();
    io_flush = 1'b1;
    drive(1'b1, 40'h9000, {8{16'h0001}}, 8'hFF, 1'b0);
    #1;
    check_eq("t36.flush_valid", 64'(io_deq_valid), 64'd0);
    check_eq("t36.flush_rdy", 64'(io_enq_ready), 64'd0);
    cyc();
    io_flush = 1'b0;
    io_enq_valid = 1'b0;
    #1;
    check_eq("t36.post_valid", 64'(io_deq_valid), 64'd0);
    io_deq_ready = 1'b1;
    drive(1'b1, 40'h7010, {112'h0, 16'h0001}, 8'h01, 1'b0);
    #1;
    check_eq("t36.post_rdy", 64'(io_enq_ready), 64'd1);
    cyc();
    io_enq_valid = 1'b0;
    #1;
    expect_out("t36.no_edge", 40'h7010, 32'h1, 1'b1, 1'b0, 1'b0);

    cyc();
    drive(1'b1, 40'hA000, {8{16'h0001}}, 8'hFF, 1'b0);
    cyc();
    io_enq_valid = 1'b0;
    #1;
    expect_out("rmid.first", 40'hA000, 32'h1, 1'b1, 1'b0, 1'b0);
    cyc();
    reset = 1'b1;
    #1;
    check_eq("rmid.valid_in_rst", 64'(io_deq_valid), 64'd0);
    check_eq("rmid.rdy_in_rst", 64'(io_enq_ready), 64'd0);
    cyc();
    reset = 1'b0;
    #1;
    check_eq("rmid.valid_after", 64'(io_deq_valid), 64'd0);
    check_eq("rmid.rdy_after", 64'(io_enq_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
